// File: rtl/segmentos_para_hex.sv
// segmentos_para_hex: turns a strobed, active-low seven-segment pattern
// into a hex digit.
// The design has four parts:
//   - a stability filter, which needs N_ESTAVEL identical strobes in a row;
//   - repeat suppression, so a digit that stays shown is not sent twice;
//   - a single-entry output buffer with a valido/pronto handshake;
//   - one-cycle pulses: erro for an illegal stable pattern, and perda for a
//     digit that was dropped because the buffer was full.
// Optional build macro: SEGMENTOS_CONTADOR_ERRO_EN. It adds the n_erros
// output, an 8-bit saturating count of erro pulses.
module segmentos_para_hex #(
    parameter int unsigned N_ESTAVEL = 3
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic [6:0] seg_in,
    input  logic       amostra,
    input  logic       pronto,
    output logic [3:0] valor,
    output logic       valido,
    output logic       erro,
    output logic       perda
`ifdef SEGMENTOS_CONTADOR_ERRO_EN
    ,
    output logic [7:0] n_erros
`endif
);

    localparam logic [6:0] BRANCO = 7'h7F;
    localparam logic [3:0] ALVO   = 4'(N_ESTAVEL);

    typedef enum logic {
        VAZIO = 1'b0,
        CHEIO = 1'b1
    } estado_t;

    estado_t    estado;
    estado_t    prox_estado;
    logic [6:0] ultimo;
    logic [3:0] cont;
    logic [6:0] emitido;
    logic       tem_emitido;

    logic       igual;
    logic       estavel;
    logic       legal;
    logic [3:0] digito_dec;
    logic       eh_branco;
    logic       digito;
    logic       ilegal;
    logic       carrega;
    logic       perda_prox;

    // Returns {legal, digit} for an active-low pattern.
    // A blank pattern and an unknown pattern both report legal = 0.
    function automatic logic [4:0] decodifica(input logic [6:0] p);
        logic [4:0] r;
        r = 5'b0_0000;
        case (p)
            7'h40: r = 5'b1_0000;
            7'h79: r = 5'b1_0001;
            7'h24: r = 5'b1_0010;
            7'h30: r = 5'b1_0011;
            7'h19: r = 5'b1_0100;
            7'h12: r = 5'b1_0101;
            7'h02: r = 5'b1_0110;
            7'h78: r = 5'b1_0111;
            7'h00: r = 5'b1_1000;
            7'h10: r = 5'b1_1001;
            7'h08: r = 5'b1_1010;
            7'h03: r = 5'b1_1011;
            7'h46: r = 5'b1_1100;
            7'h21: r = 5'b1_1101;
            7'h06: r = 5'b1_1110;
            7'h0E: r = 5'b1_1111;
            default: r = 5'b0_0000;
        endcase
        return r;
    endfunction

    // Decides whether this strobe makes the pattern stable, then classifies it.
    // The pattern becomes stable when cont is about to reach N_ESTAVEL.
    // When N_ESTAVEL is 1, any new pattern is stable on its first strobe.
    always_comb begin
        igual      = (seg_in == ultimo);
        estavel    = 1'b0;
        if (amostra) begin
            if (igual) begin
                estavel = (cont == ALVO - 4'd1);
            end else begin
                estavel = (ALVO == 4'd1);
            end
        end
        {legal, digito_dec} = decodifica(seg_in);
        eh_branco = (seg_in == BRANCO);
        digito    = estavel && legal && !(tem_emitido && (emitido == seg_in));
        ilegal    = estavel && !legal && !eh_branco;
    end

    // Stability filter: tracks the last strobed pattern and how many times
    // in a row it has been seen. The count saturates at N_ESTAVEL.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            ultimo <= BRANCO;
            cont   <= 4'd0;
        end else if (amostra) begin
            if (igual) begin
                if (cont < ALVO) begin
                    cont <= cont + 4'd1;
                end
            end else begin
                ultimo <= seg_in;
                cont   <= 4'd1;
            end
        end
    end

    // Repeat suppression: remembers the last emitted pattern.
    // A stable blank or a stable illegal pattern forgets it.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            emitido     <= BRANCO;
            tem_emitido <= 1'b0;
        end else if (digito) begin
            emitido     <= seg_in;
            tem_emitido <= 1'b1;
        end else if (estavel && !legal) begin
            tem_emitido <= 1'b0;
        end
    end

    // Output buffer FSM, next-state logic. It decides whether a new digit
    // loads into the buffer or is dropped.
    always_comb begin
        prox_estado = estado;
        carrega     = 1'b0;
        perda_prox  = 1'b0;
        case (estado)
            VAZIO: begin
                if (digito) begin
                    carrega     = 1'b1;
                    prox_estado = CHEIO;
                end
            end
            CHEIO: begin
                if (pronto) begin
                    if (digito) begin
                        carrega = 1'b1;
                    end else begin
                        prox_estado = VAZIO;
                    end
                end else if (digito) begin
                    perda_prox = 1'b1;
                end
            end
            default: prox_estado = VAZIO;
        endcase
    end

    // Registers the FSM state, the buffered digit and the event pulses.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            estado <= VAZIO;
            valor  <= 4'd0;
            valido <= 1'b0;
            erro   <= 1'b0;
            perda  <= 1'b0;
        end else begin
            estado <= prox_estado;
            valido <= (prox_estado == CHEIO);
            erro   <= ilegal;
            perda  <= perda_prox;
            if (carrega) begin
                valor <= digito_dec;
            end
        end
    end

`ifdef SEGMENTOS_CONTADOR_ERRO_EN
    // Counts erro pulses and saturates at 255.
    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            n_erros <= 8'd0;
        end else if (erro && (n_erros != 8'hFF)) begin
            n_erros <= n_erros + 8'd1;
        end
    end
`endif

endmodule

// File: tb/tb_segmentos_para_hex.sv
// Testbench for segmentos_para_hex.
// A reference model works at the level of the specification: run lengths,
// a table lookup and an output buffer. A process on the falling edge
// compares the DUT against that model on every cycle. Directed checks with
// hand-computed literal values pin the model itself.
module tb_segmentos_para_hex;

    localparam int N = 3;

    logic       Clock;
    logic       Resetn;
    logic [6:0] seg_in;
    logic       amostra;
    logic       pronto;
    logic [3:0] valor;
    logic       valido;
    logic       erro;
    logic       perda;
`ifdef SEGMENTOS_CONTADOR_ERRO_EN
    logic [7:0] n_erros;
`endif

    int vectors;
    int miscompares;

    segmentos_para_hex #(.N_ESTAVEL(N)) dut (
        .Clock   (Clock),
        .Resetn  (Resetn),
        .seg_in  (seg_in),
        .amostra (amostra),
        .pronto  (pronto),
        .valor   (valor),
        .valido  (valido),
        .erro    (erro),
        .perda   (perda)
`ifdef SEGMENTOS_CONTADOR_ERRO_EN
        ,
        .n_erros (n_erros)
`endif
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    // Reference model state.
    logic [6:0] tabela [16];
    int         run_len;
    logic [6:0] last_pat;
    int         emitted;
    logic [3:0] exp_valor;
    logic       exp_valido;
    logic       exp_erro;
    logic       exp_perda;
    int         exp_nerr;
    bit         model_ok;

    initial begin
        tabela[0]  = 7'h40; tabela[1]  = 7'h79; tabela[2]  = 7'h24; tabela[3]  = 7'h30;
        tabela[4]  = 7'h19; tabela[5]  = 7'h12; tabela[6]  = 7'h02; tabela[7]  = 7'h78;
        tabela[8]  = 7'h00; tabela[9]  = 7'h10; tabela[10] = 7'h08; tabela[11] = 7'h03;
        tabela[12] = 7'h46; tabela[13] = 7'h21; tabela[14] = 7'h06; tabela[15] = 7'h0E;
        model_ok = 1'b0;
    end

    function automatic int lookup(input logic [6:0] p);
        for (int i = 0; i < 16; i++) begin
            if (tabela[i] == p) return i;
        end
        return -1;
    endfunction

    // Model update. Each rising edge turns the present inputs into the
    // outputs that must be visible after the edge.
    always @(posedge Clock) begin : model
        int  d;
        bit  evt;
        if (!Resetn) begin
            run_len    = 0;
            last_pat   = 7'h7F;
            emitted    = -1;
            exp_valor  = 4'd0;
            exp_valido = 1'b0;
            exp_erro   = 1'b0;
            exp_perda  = 1'b0;
            exp_nerr   = 0;
            model_ok   = 1'b1;
        end else begin
            evt       = 1'b0;
            d         = -1;
            exp_erro  = 1'b0;
            exp_perda = 1'b0;
            if (amostra) begin
                if (seg_in == last_pat) begin
                    run_len++;
                end else begin
                    last_pat = seg_in;
                    run_len  = 1;
                end
                if (run_len == N) begin
                    d = lookup(seg_in);
                    if (seg_in == 7'h7F) begin
                        emitted = -1;
                    end else if (d < 0) begin
                        emitted  = -1;
                        exp_erro = 1'b1;
                        if (exp_nerr < 255) exp_nerr++;
                    end else if (emitted != int'(seg_in)) begin
                        emitted = int'(seg_in);
                        evt     = 1'b1;
                    end
                end
            end
            if (evt) begin
                if (!exp_valido || pronto) begin
                    exp_valor  = 4'(d);
                    exp_valido = 1'b1;
                end else begin
                    exp_perda = 1'b1;
                end
            end else if (exp_valido && pronto) begin
                exp_valido = 1'b0;
            end
        end
    end

    // Compares the DUT against the model on every falling edge.
    always @(negedge Clock) begin
        if (model_ok) begin
            vectors++;
            if ({valor, valido, erro, perda} !== {exp_valor, exp_valido, exp_erro, exp_perda}) begin
                miscompares++;
                $display("[TB] FAIL model t=%0t: valor/valido/erro/perda got %h/%b/%b/%b want %h/%b/%b/%b",
                         $time, valor, valido, erro, perda, exp_valor, exp_valido, exp_erro, exp_perda);
            end
`ifdef SEGMENTOS_CONTADOR_ERRO_EN
            vectors++;
            if (int'(n_erros) != exp_nerr) begin
                miscompares++;
                $display("[TB] FAIL n_erros t=%0t: got %0d want %0d", $time, n_erros, exp_nerr);
            end
`endif
        end
    end

    // Drives one cycle of inputs. Returns 1 time unit after the rising edge.
    task automatic applyStimulus(input logic [6:0] s, input logic a, input logic p);
        seg_in  = s;
        amostra = a;
        pronto  = p;
        @(posedge Clock);
        #1;
    endtask

    task automatic strobe(input logic [6:0] s, input logic p, input int k);
        for (int i = 0; i < k; i++) applyStimulus(s, 1'b1, p);
    endtask

    task automatic idle(input logic p);
        applyStimulus(7'h7F, 1'b0, p);
    endtask

    // Checks the DUT outputs against hand-computed values.
    task automatic checkOutput(input string name, input logic [3:0] v, input logic vd,
                               input logic e, input logic pe);
        vectors++;
        if ({valor, valido, erro, perda} !== {v, vd, e, pe}) begin
            miscompares++;
            $display("[TB] FAIL %s: valor/valido/erro/perda got %h/%b/%b/%b want %h/%b/%b/%b",
                     name, valor, valido, erro, perda, v, vd, e, pe);
        end
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vectors     = 0;
        miscompares = 0;
        Resetn      = 1'b0;
        applyStimulus(7'h7F, 1'b0, 1'b1);
        applyStimulus(7'h24, 1'b1, 1'b1);
        checkOutput("reset", 4'h0, 1'b0, 1'b0, 1'b0);
        Resetn = 1'b1;

        // Basic digit, latency and drain.
        strobe(7'h24, 1'b1, 2);
        checkOutput("r28_not_yet", 4'h0, 1'b0, 1'b0, 1'b0);
        strobe(7'h24, 1'b1, 1);
        checkOutput("r28_digit", 4'h2, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        checkOutput("r28_drain", 4'h2, 1'b0, 1'b0, 1'b0);

        // Blank, then a filter restart with gaps between strobes.
        strobe(7'h7F, 1'b1, 3);
        strobe(7'h24, 1'b1, 1);
        idle(1'b1);
        strobe(7'h24, 1'b1, 1);
        strobe(7'h79, 1'b1, 1);
        strobe(7'h24, 1'b1, 1);
        idle(1'b1);
        idle(1'b1);
        strobe(7'h24, 1'b1, 1);
        checkOutput("r29_restart", 4'h2, 1'b0, 1'b0, 1'b0);
        strobe(7'h24, 1'b1, 1);
        checkOutput("r29_digit", 4'h2, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Repeat suppression and re-emission after a blank.
        strobe(7'h12, 1'b1, 3);
        checkOutput("r30_first", 4'h5, 1'b1, 1'b0, 1'b0);
        strobe(7'h12, 1'b1, 2);
        checkOutput("r30_no_repeat", 4'h5, 1'b0, 1'b0, 1'b0);
        strobe(7'h7F, 1'b1, 3);
        strobe(7'h12, 1'b1, 3);
        checkOutput("r30_after_blank", 4'h5, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Illegal pattern.
        strobe(7'h7E, 1'b1, 3);
        checkOutput("r31_erro", 4'h5, 1'b0, 1'b1, 1'b0);
        idle(1'b1);
        checkOutput("r31_pulse_end", 4'h5, 1'b0, 1'b0, 1'b0);
        strobe(7'h7E, 1'b1, 1);
        checkOutput("r31_no_repeat", 4'h5, 1'b0, 1'b0, 1'b0);
`ifdef SEGMENTOS_CONTADOR_ERRO_EN
        vectors++;
        if (n_erros !== 8'd1) begin
            miscompares++;
            $display("[TB] FAIL r31_n_erros: got %0d want 1", n_erros);
        end
`endif

        // Back-pressure, dropped digit and same-cycle swap.
        strobe(7'h30, 1'b0, 3);
        checkOutput("r32_load", 4'h3, 1'b1, 1'b0, 1'b0);
        strobe(7'h19, 1'b0, 3);
        checkOutput("r32_perda", 4'h3, 1'b1, 1'b0, 1'b1);
        strobe(7'h02, 1'b0, 1);
        checkOutput("r32_hold", 4'h3, 1'b1, 1'b0, 1'b0);
        strobe(7'h02, 1'b0, 1);
        strobe(7'h02, 1'b1, 1);
        checkOutput("r32_swap", 4'h6, 1'b1, 1'b0, 1'b0);
        idle(1'b0);
        checkOutput("r32_stable", 4'h6, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        checkOutput("r32_drain", 4'h6, 1'b0, 1'b0, 1'b0);

        // Reset while the buffer is full, then the same digit again.
        strobe(7'h08, 1'b0, 3);
        checkOutput("r33_load", 4'hA, 1'b1, 1'b0, 1'b0);
        Resetn = 1'b0;
        applyStimulus(7'h08, 1'b1, 1'b0);
        checkOutput("r33_reset", 4'h0, 1'b0, 1'b0, 1'b0);
        Resetn = 1'b1;
        strobe(7'h08, 1'b1, 3);
        checkOutput("r33_again", 4'hA, 1'b1, 1'b0, 1'b0);
        idle(1'b1);

        // Reset in the middle of filtering restarts the run.
        strobe(7'h21, 1'b1, 2);
        Resetn = 1'b0;
        applyStimulus(7'h21, 1'b1, 1'b1);
        Resetn = 1'b1;
        strobe(7'h21, 1'b1, 2);
        checkOutput("midreset_none", 4'h0, 1'b0, 1'b0, 1'b0);
        strobe(7'h21, 1'b1, 1);
        checkOutput("midreset_digit", 4'hD, 1'b1, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/segmentos_para_hex.md
SEGMENTOS_PARA_HEX -- requirements
Module: segmentos_para_hex

Interface
REQ-001 Parameter: N_ESTAVEL, default 3, consecutive identical strobed patterns needed to accept a digit (legal range 1..15).
REQ-002 Port: Clock  in  1  single clock; all state updates on its rising edge.
REQ-003 Port: Resetn  in  1  reset, synchronous to Clock, active-low.
REQ-004 Port: seg_in  in  7  seven-segment pattern, active-low (0 = segment lit), bit6=g .. bit0=a.
REQ-005 Port: amostra  in  1  strobe: seg_in is sampled only in cycles where amostra=1.
REQ-006 Port: valor  out  4  decoded hex digit.
REQ-007 Port: valido  out  1  valor holds an undelivered digit.
REQ-008 Port: pronto  in  1  consumer accepts valor in a cycle where valido=1 and pronto=1.
REQ-009 Port: erro  out  1  one-cycle pulse: a stable pattern was not a legal code.
REQ-010 Port: perda  out  1  one-cycle pulse: an accepted digit was dropped because the output was occupied.

Function
REQ-011 Decode table (seg_in hex -> valor): 40->0, 79->1, 24->2, 30->3, 19->4, 12->5, 02->6, 78->7, 00->8, 10->9, 08->A, 03->B, 46->C, 21->D, 06->E, 0E->F; 7F = blank; every other pattern = illegal.
REQ-012 Stability filter: registers ultimo (7 bits) and cont (4 bits); on amostra=1, if seg_in==ultimo then cont increments saturating at N_ESTAVEL, else ultimo<=seg_in and cont<=1.
REQ-013 A pattern becomes stable on the strobe where cont reaches N_ESTAVEL (with N_ESTAVEL=1: every strobe of a new pattern); further identical strobes after saturation produce no new event.
REQ-014 Suppression: register emitido (7 bits) plus flag tem_emitido; a stable legal digit equal to emitido while tem_emitido=1 produces no event.
REQ-015 Stable legal digit not suppressed: event "digito"; emitido<=pattern, tem_emitido<=1.
REQ-016 Stable blank (7F): tem_emitido<=0, no output event; the same digit after a blank is emitted again.
REQ-017 Stable illegal pattern: erro=1 for exactly the next cycle; tem_emitido<=0; valor/valido unchanged.
REQ-018 Output FSM states: VAZIO (valido=0), CHEIO (valido=1).
REQ-019 VAZIO + digito: next cycle valor=decoded digit, valido=1, state CHEIO; latency one cycle after the Nth strobe.
REQ-020 CHEIO + pronto=1 and no digito: next cycle valido=0, state VAZIO; valor holds its last value.
REQ-021 CHEIO + pronto=1 + digito in the same cycle: new digit loaded, valido stays 1, no perda.
REQ-022 CHEIO + pronto=0 + digito: digit discarded, perda=1 for the next cycle, valor and valido unchanged.
REQ-023 valor and valido are stable while valido=1 and pronto=0.
REQ-024 amostra=0 cycles leave the filter unchanged, regardless of gaps between strobes.

Reset
REQ-025 Resetn=0 at a rising edge forces: valor=0, valido=0, erro=0, perda=0, state VAZIO, ultimo=7F, cont=0, emitido=7F, tem_emitido=0.
REQ-026 Reset takes priority over all inputs; a reset mid-filter or while CHEIO discards the pending digit without erro or perda.

Configuration
REQ-027 Macro SEGMENTOS_CONTADOR_ERRO_EN: when defined, adds output port n_erros (8 bits), an erro-pulse counter saturating at 255 and cleared by reset; when undefined, the port and the counter do not exist and all other behaviour is identical.

Verification
REQ-028 N_ESTAVEL=3, pronto=1, strobes seg_in=24,24,24 -> one cycle after the 3rd strobe valor=2, valido=1; then valido=0 the following cycle.
REQ-029 Strobes 24,24,79,24,24 -> no digit event (filter restarts on 79); a 3rd 24 -> valor=2.
REQ-030 Strobes 12 x5 -> one digit event only (valor=5); then 7F x3, 12 x3 -> a second event, valor=5.
REQ-031 Strobes 7E x3 -> erro pulses one cycle, valido unchanged (n_erros=1 when macro defined).
REQ-032 pronto=0: 30 x3 then 19 x3 -> valor=3 held with valido=1, perda pulses once; raise pronto together with a third digit 02 x3 -> valor=6 with valido continuously 1.
REQ-033 Resetn=0 while CHEIO with valor=A -> next cycle valor=0, valido=0; after release, strobes 08 x3 -> valor=A emitted (no suppression).
